kirby_motion: RTL and testbench

Parametrised player-sprite controller for the VGA game path. It tracks the player character's position, velocity and facing from up to `N_KEYS` simultaneous USB keycodes. It applies walking, gravity, multi-jump (float) and screen-bound clamping once per frame, and produces the per-pixel hit flag plus sprite-local offsets for the sprite ROM. It sits between the keyboard interface and the colour mapper.

---
 rtl/kirby_motion.sv | 231 +++++++++++++++++++++++
 tb/tb_kirby_motion.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kirby_motion.sv
// Player-sprite motion controller: frame-strobe synchroniser, walk/jump/gravity
// integration with screen clamping, and a registered per-pixel sprite hit test.
module kirby_motion #(
  parameter int          SPR_W     = 32,
  parameter int          SPR_H     = 32,
  parameter int          X_MIN     = 0,
  parameter int          X_MAX     = 640,
  parameter int          Y_MIN     = 0,
  parameter int          Y_GROUND  = 400,
  parameter int          X_START   = 64,
  parameter int          WALK_V    = 2,
  parameter int          JUMP_V    = 8,
  parameter int          GRAVITY   = 1,
  parameter int          MAX_FALL  = 6,
  parameter int          N_JUMPS   = 3,
  parameter int          N_KEYS    = 4,
  parameter logic [7:0]  KEY_LEFT  = 8'h04,
  parameter logic [7:0]  KEY_RIGHT = 8'h07,
  parameter logic [7:0]  KEY_JUMP  = 8'h1A
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic                       frame_clk,
  input  logic [8*N_KEYS-1:0]        keycodes,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  output logic [9:0]                 pos_x,
  output logic [9:0]                 pos_y,
  output logic                       facing_left,
  output logic                       airborne,
  output logic                       is_kirby,
  output logic [$clog2(SPR_W)-1:0]   spr_x,
  output logic [$clog2(SPR_H)-1:0]   spr_y
);

  localparam int SXW     = $clog2(SPR_W);
  localparam int SYW     = $clog2(SPR_H);
  localparam int JW      = $clog2(N_JUMPS + 1);
  localparam int FLOOR_Y = Y_GROUND - SPR_H;
  localparam int X_HI    = X_MAX - SPR_W;

  localparam logic [0:0] ST_GROUND = 1'b0;
  localparam logic [0:0] ST_AIR    = 1'b1;

  localparam logic signed [10:0] C_X_MIN    = 11'(X_MIN);
  localparam logic signed [10:0] C_X_HI     = 11'(X_HI);
  localparam logic signed [10:0] C_Y_MIN    = 11'(Y_MIN);
  localparam logic signed [10:0] C_FLOOR    = 11'(FLOOR_Y);
  localparam logic signed [10:0] C_MAX_FALL = 11'(MAX_FALL);
  localparam logic signed [10:0] C_JUMP_V   = 11'(JUMP_V);
  localparam logic signed [10:0] C_WALK_V   = 11'(WALK_V);
  localparam logic signed [10:0] C_GRAVITY  = 11'(GRAVITY);

  // frame strobe synchroniser and edge detector
  logic r_fc_meta, r_fc_sync, r_fc_prev, r_tick;

  // motion state
  logic [9:0]        r_pos_x, r_pos_y;
  logic signed [7:0] r_vy;
  logic [JW-1:0]     r_jumps_used;
  logic [0:0]        r_state;
  logic              r_facing_left;
  logic              r_jump_prev;

  // hit-test registers
  logic              r_hit;
  logic [SXW-1:0]    r_spr_x;
  logic [SYW-1:0]    r_spr_y;

  // NOTE: every flop below uses <= so all registers see the pre-edge values of
  // their neighbours; a blocking = here would make the chain collapse into one stage.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_fc_meta <= 1'b0;
      r_fc_sync <= 1'b0;
      r_fc_prev <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_fc_meta <= frame_clk;
      r_fc_sync <= r_fc_meta;
      r_fc_prev <= r_fc_sync;
      r_tick    <= r_fc_sync & ~r_fc_prev;
    end
  end

  logic w_left, w_right, w_jump;

  // NOTE: each always_comb output gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_left  = 1'b0;
    w_right = 1'b0;
    w_jump  = 1'b0;
    for (int k = 0; k < N_KEYS; k++) begin
      if (keycodes[8*k +: 8] == KEY_LEFT)  w_left  = 1'b1;
      if (keycodes[8*k +: 8] == KEY_RIGHT) w_right = 1'b1;
      if (keycodes[8*k +: 8] == KEY_JUMP)  w_jump  = 1'b1;
    end
  end

  logic signed [10:0] w_vx, w_x_sum;
  logic [9:0]         w_x_next;
  logic               w_facing_next;

  always_comb begin
    w_vx          = 11'sd0;
    w_facing_next = r_facing_left;
    if (w_left && !w_right) begin
      w_vx          = -C_WALK_V;
      w_facing_next = 1'b1;
    end else if (w_right && !w_left) begin
      w_vx          = C_WALK_V;
      w_facing_next = 1'b0;
    end
    w_x_sum = $signed({1'b0, r_pos_x}) + w_vx;
    if (w_x_sum < C_X_MIN)     w_x_next = 10'(X_MIN);
    else if (w_x_sum > C_X_HI) w_x_next = 10'(X_HI);
    else                       w_x_next = w_x_sum[9:0];
  end

  logic               w_jump_edge;
  logic signed [10:0] w_vy_ext, w_vy_sum, w_vy_upd, w_y_base, w_y_sum;
  logic signed [7:0]  w_vy_next;
  logic [9:0]         w_y_next;
  logic [JW-1:0]      w_jumps_next;
  logic [0:0]         w_state_next;

  assign w_jump_edge = w_jump & ~r_jump_prev;
  assign w_vy_ext    = {{3{r_vy[7]}}, r_vy};

  always_comb begin
    w_state_next = r_state;
    w_jumps_next = r_jumps_used;
    w_y_base     = $signed({1'b0, r_pos_y});
    w_vy_sum     = w_vy_ext + C_GRAVITY;
    w_vy_upd     = w_vy_ext;
    case (r_state)
      ST_GROUND: begin
        if (w_jump_edge) begin
          w_vy_upd     = -C_JUMP_V;
          w_jumps_next = JW'(1);
          w_state_next = ST_AIR;
        end else begin
          w_vy_upd = 11'sd0;
          w_y_base = C_FLOOR;
        end
      end
      default: begin
        if (w_jump_edge && (r_jumps_used < JW'(N_JUMPS))) begin
          w_vy_upd     = -C_JUMP_V;
          w_jumps_next = r_jumps_used + JW'(1);
        end else begin
          w_vy_upd = (w_vy_sum > C_MAX_FALL) ? C_MAX_FALL : w_vy_sum;
        end
      end
    endcase

    // integrate with the freshly updated vy, then resolve floor and ceiling
    w_y_sum   = w_y_base + w_vy_upd;
    w_vy_next = w_vy_upd[7:0];
    if (w_y_sum >= C_FLOOR) begin
      w_y_next     = 10'(FLOOR_Y);
      w_vy_next    = 8'sd0;
      w_jumps_next = '0;
      w_state_next = ST_GROUND;
    end else if (w_y_sum < C_Y_MIN) begin
      w_y_next  = 10'(Y_MIN);
      w_vy_next = 8'sd0;
    end else begin
      w_y_next = w_y_sum[9:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_pos_x       <= 10'(X_START);
      r_pos_y       <= 10'(FLOOR_Y);
      r_vy          <= 8'sd0;
      r_jumps_used  <= '0;
      r_state       <= ST_GROUND;
      r_facing_left <= 1'b0;
      r_jump_prev   <= 1'b0;
    end else if (r_tick) begin
      r_pos_x       <= w_x_next;
      r_pos_y       <= w_y_next;
      r_vy          <= w_vy_next;
      r_jumps_used  <= w_jumps_next;
      r_state       <= w_state_next;
      r_facing_left <= w_facing_next;
      r_jump_prev   <= w_jump;
    end
  end

  // 11-bit unsigned bounds so a sprite near the right edge cannot wrap
  logic [10:0]    w_dx, w_dy, w_px, w_py, w_px_end, w_py_end;
  logic           w_hit;
  logic [SXW-1:0] w_off_x;
  logic [SYW-1:0] w_off_y;

  assign w_dx     = {1'b0, DrawX};
  assign w_dy     = {1'b0, DrawY};
  assign w_px     = {1'b0, r_pos_x};
  assign w_py     = {1'b0, r_pos_y};
  assign w_px_end = w_px + 11'(SPR_W);
  assign w_py_end = w_py + 11'(SPR_H);
  assign w_hit    = (w_dx >= w_px) && (w_dx < w_px_end) &&
                    (w_dy >= w_py) && (w_dy < w_py_end);
  assign w_off_x  = DrawX[SXW-1:0] - r_pos_x[SXW-1:0];
  assign w_off_y  = DrawY[SYW-1:0] - r_pos_y[SYW-1:0];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hit   <= 1'b0;
      r_spr_x <= '0;
      r_spr_y <= '0;
    end else begin
      r_hit   <= w_hit;
      r_spr_x <= w_off_x;
      r_spr_y <= w_off_y;
    end
  end

  assign pos_x       = r_pos_x;
  assign pos_y       = r_pos_y;
  assign facing_left = r_facing_left;
  assign airborne    = (r_state == ST_AIR);
  assign is_kirby    = r_hit;
  assign spr_x       = r_spr_x;
  assign spr_y       = r_spr_y;

endmodule

// File: tb/tb_kirby_motion.sv
// Self-checking bench for kirby_motion: a frame-level behavioural model plus a
// per-cycle compare process, randomized key/pixel stimulus and literal anchors.
module tb_kirby_motion;

  localparam int SPR_W    = 32;
  localparam int SPR_H    = 32;
  localparam int X_MAX    = 640;
  localparam int X_START  = 64;
  localparam int FLOOR_Y  = 400 - SPR_H;
  localparam int WALK_V   = 2;
  localparam int JUMP_V   = 8;
  localparam int GRAVITY  = 1;
  localparam int MAX_FALL = 6;
  localparam int N_JUMPS  = 3;
  localparam logic [7:0] K_L = 8'h04;
  localparam logic [7:0] K_R = 8'h07;
  localparam logic [7:0] K_J = 8'h1A;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [31:0] keycodes = '0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [9:0]  pos_x, pos_y;
  logic        facing_left, airborne, is_kirby;
  logic [4:0]  spr_x, spr_y;

  kirby_motion dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .keycodes(keycodes),
    .DrawX(DrawX), .DrawY(DrawY), .pos_x(pos_x), .pos_y(pos_y),
    .facing_left(facing_left), .airborne(airborne), .is_kirby(is_kirby),
    .spr_x(spr_x), .spr_y(spr_y)
  );

  always #10 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state (whole-frame granularity)
  int m_x, m_y, m_vy, m_jumps, m_air, m_facing, m_jprev;
  bit settled   = 1'b1;
  bit rand_draw = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_x = X_START; m_y = FLOOR_Y; m_vy = 0; m_jumps = 0;
    m_air = 0; m_facing = 0; m_jprev = 0;
  endfunction

  function automatic void model_step(input logic [31:0] keys);
    bit l, r, j, edge_j;
    int x;
    l = 0; r = 0; j = 0;
    for (int s = 0; s < 4; s++) begin
      if (keys[8*s +: 8] == K_L) l = 1;
      if (keys[8*s +: 8] == K_R) r = 1;
      if (keys[8*s +: 8] == K_J) j = 1;
    end
    x = m_x;
    if (l && !r) begin x = x - WALK_V; m_facing = 1; end
    if (r && !l) begin x = x + WALK_V; m_facing = 0; end
    if (x < 0) x = 0;
    if (x > X_MAX - SPR_W) x = X_MAX - SPR_W;
    m_x = x;
    edge_j = j && !m_jprev;
    m_jprev = j;
    if (!m_air) begin
      if (edge_j) begin m_vy = -JUMP_V; m_jumps = 1; m_air = 1; end
      else begin m_vy = 0; m_y = FLOOR_Y; end
    end else if (edge_j && m_jumps < N_JUMPS) begin
      m_vy = -JUMP_V; m_jumps++;
    end else begin
      m_vy = (m_vy + GRAVITY > MAX_FALL) ? MAX_FALL : m_vy + GRAVITY;
    end
    m_y = m_y + m_vy;
    if (m_y >= FLOOR_Y) begin
      m_y = FLOOR_Y; m_vy = 0; m_jumps = 0; m_air = 0;
    end else if (m_y < 0) begin
      m_y = 0; m_vy = 0;
    end
  endfunction

  function automatic logic [31:0] put(input logic [31:0] k, input int slot, input logic [7:0] code);
    logic [31:0] t;
    t = k;
    t[8*slot +: 8] = code;
    return t;
  endfunction

  // one frame strobe; the update must land on the 4th edge after the rise
  task automatic do_frame(input logic [31:0] keys);
    @(posedge Clk); #1;
    keycodes  = keys;
    settled   = 1'b0;
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check("pre_tick_x", pos_x, m_x);
    check("pre_tick_y", pos_y, m_y);
    @(posedge Clk); #1;
    model_step(keys);
    settled = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    frame_clk = 1'b0;
    repeat (3) @(posedge Clk);
  endtask

  task automatic do_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
  endtask

  // random pixel driver, biased to land around the sprite edges
  initial begin
    forever begin
      @(posedge Clk); #1;
      if (rand_draw) begin
        int tx, ty;
        tx = m_x - 4 + int'($urandom_range(0, 40));
        ty = m_y - 4 + int'($urandom_range(0, 40));
        if ($urandom_range(0, 7) == 0) begin
          tx = int'($urandom_range(0, 1023));
          ty = int'($urandom_range(0, 1023));
        end
        if (tx < 0) tx = 0;
        if (ty < 0) ty = 0;
        DrawX = 10'(tx);
        DrawY = 10'(ty);
      end
    end
  end

  // per-cycle compare against the model
  initial begin
    bit e_valid, e_hit;
    int e_sx, e_sy;
    forever begin
      @(posedge Clk);
      e_valid = Reset_n;
      e_hit   = (int'(DrawX) >= m_x) && (int'(DrawX) < m_x + SPR_W) &&
                (int'(DrawY) >= m_y) && (int'(DrawY) < m_y + SPR_H);
      e_sx    = (int'(DrawX) - m_x) & (SPR_W - 1);
      e_sy    = (int'(DrawY) - m_y) & (SPR_H - 1);
      @(negedge Clk);
      if (!Reset_n) begin
        check("rst_pos_x", pos_x, X_START);
        check("rst_pos_y", pos_y, FLOOR_Y);
        check("rst_air", airborne, 0);
        check("rst_face", facing_left, 0);
        check("rst_hit", is_kirby, 0);
        check("rst_spr", {spr_y, spr_x}, 0);
      end else begin
        if (settled) begin
          check("pos_x", pos_x, m_x);
          check("pos_y", pos_y, m_y);
          check("facing_left", facing_left, m_facing);
          check("airborne", airborne, m_air);
        end
        check("is_kirby", is_kirby, int'(e_valid && e_hit));
        if (e_valid && e_hit) begin
          check("spr_x", spr_x, e_sx);
          check("spr_y", spr_y, e_sy);
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] k;
    model_reset();
    repeat (3) @(posedge Clk);
    #1;
    check("reset_is_kirby", is_kirby, 0);
    check("reset_pos_y", pos_y, 368);
    Reset_n = 1'b1;
    rand_draw = 1'b1;

    repeat (5) do_frame('0);
    check("idle_pos_x", pos_x, 64);
    check("idle_pos_y", pos_y, 368);
    check("idle_air", airborne, 0);

    repeat (10) do_frame(put('0, 2, K_R));
    check("walk_right_x", pos_x, 84);
    check("walk_right_face", facing_left, 0);
    repeat (3) do_frame(put(put('0, 0, K_L), 3, K_R));
    check("both_keys_x", pos_x, 84);
    check("both_keys_face", facing_left, 0);

    do_reset();
    for (int f = 1; f <= 40; f++) begin
      do_frame(put('0, f % 4, K_L));
      if (f == 31) check("left_f31_x", pos_x, 2);
      if (f == 32) check("left_f32_x", pos_x, 0);
    end
    check("left_clamp_x", pos_x, 0);
    check("left_face", facing_left, 1);
    repeat (310) do_frame(put('0, 1, K_R));
    check("right_clamp_x", pos_x, 608);

    // park the sprite at (100,368) for the literal hit test
    do_reset();
    repeat (18) do_frame(put('0, 0, K_R));
    check("park_x", pos_x, 100);
    rand_draw = 1'b0;
    @(posedge Clk); #1;
    DrawX = 10'd131; DrawY = 10'd399;
    @(posedge Clk); #1;
    check("hit_corner", is_kirby, 1);
    check("hit_spr_x", spr_x, 31);
    check("hit_spr_y", spr_y, 31);
    DrawX = 10'd132;
    @(posedge Clk); #1;
    check("miss_right", is_kirby, 0);
    DrawX = 10'd100; DrawY = 10'd368;
    @(posedge Clk); #1;
    check("hit_origin", is_kirby, 1);
    check("origin_spr", {spr_y, spr_x}, 0);
    DrawX = 10'd99;
    @(posedge Clk); #1;
    check("miss_left", is_kirby, 0);
    rand_draw = 1'b1;

    // single jump, held throughout
    for (int f = 1; f <= 30; f++) begin
      do_frame(put('0, 3, K_J));
      if (f == 1) check("jump_y1", pos_y, 360);
      if (f == 2) check("jump_y2", pos_y, 353);
      if (f == 3) check("jump_y3", pos_y, 347);
      if (f == 4) check("jump_y4", pos_y, 342);
    end
    check("land_y", pos_y, 368);
    check("land_air", airborne, 0);
    do_frame('0);

    // four presses: the fourth falls outside the jump budget
    for (int f = 1; f <= 7; f++) do_frame((f % 2) ? put('0, f % 4, K_J) : '0);
    check("multi_jump_y", pos_y, 317);
    repeat (40) do_frame('0);
    check("multi_land_air", airborne, 0);
    do_frame(put('0, 0, K_J));
    check("rejump_y", pos_y, 360);
    check("rejump_air", airborne, 1);
    repeat (2) do_frame(put('0, 0, K_J));

    // asynchronous reset mid-jump
    @(posedge Clk); #3;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_y", pos_y, 368);
    check("async_rst_x", pos_x, 64);
    check("async_rst_air", airborne, 0);
    check("async_rst_hit", is_kirby, 0);
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    do_frame('0);
    check("post_rst_y", pos_y, 368);
    check("post_rst_air", airborne, 0);

    // randomized key mix across all slots, with unrelated keycodes as noise
    for (int f = 0; f < 120; f++) begin
      k = '0;
      for (int s = 0; s < 4; s++) begin
        case ($urandom_range(0, 5))
          0: k = put(k, s, K_L);
          1: k = put(k, s, K_R);
          2: k = put(k, s, K_J);
          3: k = put(k, s, 8'(8'h10 + $urandom_range(0, 15)));
          default: ;
        endcase
      end
      do_frame(k);
    end

    repeat (4) @(posedge Clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
